// File: rtl/sklansky_share_arbiter.sv
// Round-robin arbiter sharing one sklansky prefix adder among NREQ
// requesters; ports: clk/rst, req_valid/ready/a/b, rsp_valid/ready/sum/cout/id, busy.

module sklansky_generic #(
  parameter int N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         cout
);
  localparam int L = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0] g, p, gs, ps, gn, pn;

  // Sklansky tree: at level l, every bit whose bit l is set merges with
  // the top bit of the preceding 2^l-aligned block.
  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gs = g;
    ps = p;
    gn = g;
    pn = p;
    for (int l = 0; l < L; l++) begin
      gn = gs;
      pn = ps;
      for (int i = 0; i < N; i++) begin
        if (((i >> l) & 1) == 1) begin
          int j;
          j = ((i >> l) << l) - 1;
          gn[i] = gs[i] | (ps[i] & gs[j]);
          pn[i] = ps[i] & ps[j];
        end
      end
      gs = gn;
      ps = pn;
    end
    sum[0] = p[0];
    for (int i = 1; i < N; i++) begin
      sum[i] = p[i] ^ gs[i-1];
    end
    cout = gs[N-1];
  end
endmodule

module sklansky_share_arbiter #(
  parameter int N = 64,
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [N-1:0]      rsp_sum,
  output logic              rsp_cout,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy
);
  typedef enum logic [1:0] {
    IDLE,
    ADD,
    RESP
  } state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [N-1:0]   op_a;
  logic [N-1:0]   op_b;
  logic [IDW-1:0] op_id;
  logic [N-1:0]   sum_w;
  logic           cout_w;
  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;

  sklansky_generic #(.N(N)) u_add (
    .a    (op_a),
    .b    (op_b),
    .sum  (sum_w),
    .cout (cout_w)
  );

  // First valid requester after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    int idx;
    idx = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && !rst && gnt_any) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= IDW'(NREQ - 1);
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_any) begin
            op_a   <= req_a[gnt_idx*N +: N];
            op_b   <= req_b[gnt_idx*N +: N];
            op_id  <= gnt_idx;
            rr_ptr <= gnt_idx;
            state  <= ADD;
          end
        end
        ADD: begin
          rsp_sum   <= sum_w;
          rsp_cout  <= cout_w;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sklansky_share_arbiter.sv
// Randomized + directed bench for sklansky_share_arbiter (N=8, NREQ=4)
// against a queue-based transaction model.

module tb_sklansky_share_arbiter;
  localparam int N = 8;
  localparam int NREQ = 4;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [N-1:0]      rsp_sum;
  logic              rsp_cout;
  logic [IDW-1:0]    rsp_id;
  logic              busy;

  logic [NREQ-1:0] dv;
  logic [N-1:0]    da [NREQ];
  logic [N-1:0]    db [NREQ];
  logic            dr;
  logic            drst;

  always #5 clk = ~clk;

  assign rst       = drst;
  assign req_valid = dv;
  assign rsp_ready = dr;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
    assign req_a[gi*N +: N] = da[gi];
    assign req_b[gi*N +: N] = db[gi];
  end

  sklansky_share_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int id;
    int total;
  } op_t;

  op_t        q[$];
  int         grant_log[$];
  int         grant_cyc[$];
  int         m_phase = 0;
  int         m_last = NREQ - 1;
  logic       m_rv = 1'b0;
  logic [N-1:0] m_sum = '0;
  logic       m_cout = 1'b0;
  int         m_id = 0;
  int         waitc[NREQ];
  int         cyc = 0;
  int         rsp_count = 0;
  int         drop = -1;
  bit         hold_all = 1'b0;

  task automatic step();
    int win;
    int t;
    logic [NREQ-1:0] exp_rdy;
    #1;
    win = -1;
    if (m_phase == 0 && !drst) begin
      for (int k = 1; k <= NREQ; k++) begin
        int i;
        i = (m_last + k) % NREQ;
        if (win < 0 && dv[i]) win = i;
      end
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    check("req_ready", req_ready, exp_rdy);
    if (drst) begin
      m_phase = 0; m_last = NREQ - 1; m_rv = 0;
      m_sum = '0; m_cout = 0; m_id = 0;
      q.delete();
      for (int i = 0; i < NREQ; i++) waitc[i] = 0;
    end else begin
      case (m_phase)
        0: if (win >= 0) begin
          check("fair_wait", waitc[win] < NREQ, 1);
          for (int i = 0; i < NREQ; i++)
            if (dv[i] && i != win) waitc[i]++;
          waitc[win] = 0;
          q.push_back('{win, int'(da[win]) + int'(db[win])});
          grant_log.push_back(win);
          grant_cyc.push_back(cyc);
          m_last = win;
          m_phase = 1;
          drop = win;
        end
        1: begin
          t = q[0].total;
          m_rv = 1; m_sum = t[N-1:0]; m_cout = t[N];
          m_id = q[0].id; m_phase = 2;
        end
        default: if (dr) begin
          m_rv = 0; m_phase = 0;
          void'(q.pop_front());
          rsp_count++;
        end
      endcase
    end
    @(posedge clk);
    #1;
    cyc++;
    if (drop >= 0) begin
      if (hold_all) begin
        da[drop] = N'($urandom);
        db[drop] = N'($urandom);
      end else begin
        dv[drop] = 1'b0;
      end
      drop = -1;
    end
    check("rsp_valid", rsp_valid, m_rv);
    check("busy", busy, m_phase != 0);
    check("rsp_sum", rsp_sum, m_sum);
    check("rsp_cout", rsp_cout, m_cout);
    check("rsp_id", rsp_id, m_id);
  endtask

  task automatic do_reset();
    drst = 1; dv = '0; dr = 1;
    step(); step();
    drst = 0;
  endtask

  task automatic run_one(string tag, int i, int a, int b,
                         int es, int ec);
    dv = '0; dv[i] = 1'b1;
    da[i] = N'(a); db[i] = N'(b); dr = 1;
    step();
    check({tag, "_busy1"}, busy, 1);
    check({tag, "_rv1"}, rsp_valid, 0);
    step();
    check({tag, "_rv2"}, rsp_valid, 1);
    check({tag, "_sum"}, rsp_sum, es);
    check({tag, "_cout"}, rsp_cout, ec);
    check({tag, "_id"}, rsp_id, i);
    step();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int gl0;
    int rc0;
    logic [N-1:0] s0;
    dv = '0; dr = 1; drst = 1;
    for (int i = 0; i < NREQ; i++) begin
      da[i] = '0; db[i] = '0; waitc[i] = 0;
    end
    @(posedge clk);
    do_reset();
    check("rst_rv", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", rsp_sum, 0);

    dv = 4'b0001; da[0] = 8'h3C; db[0] = 8'h0F;
    #1;
    check("t1_ready", req_ready, 4'b0001);
    run_one("t1", 0, 8'h3C, 8'h0F, 8'h4B, 0);
    run_one("wrap", 2, 8'hFF, 8'h01, 8'h00, 1);
    run_one("ffff", 2, 8'hFF, 8'hFF, 8'hFE, 1);

    do_reset();
    hold_all = 1;
    for (int i = 0; i < NREQ; i++) begin
      da[i] = N'(8'h11 * (i + 1));
      db[i] = N'(8'h20 + i);
    end
    dv = '1;
    gl0 = grant_log.size();
    repeat (16) step();
    for (int k = 0; k < 5; k++)
      check("rr_order", grant_log[gl0+k], k % NREQ);
    for (int k = 1; k < 5; k++)
      check("rr_gap", grant_cyc[gl0+k] - grant_cyc[gl0+k-1], 3);
    hold_all = 0;
    while (busy) step();
    dv = '0;
    step();

    dv = 4'b0010; da[1] = 8'hA5; db[1] = 8'h5A; dr = 0;
    step(); step();
    dv = 4'b0101;
    da[0] = 8'h01; db[0] = 8'h02;
    da[2] = 8'h03; db[2] = 8'h04;
    s0 = rsp_sum;
    check("bp_sum0", s0, 8'hFF);
    for (int k = 0; k < 10; k++) begin
      step();
      check("bp_valid", rsp_valid, 1);
      check("bp_sum", rsp_sum, s0);
      check("bp_id", rsp_id, 1);
    end
    dr = 1;
    gl0 = grant_log.size();
    step();
    check("bp_nogrant", grant_log.size(), gl0);
    step();
    check("bp_grant", grant_log.size(), gl0 + 1);
    check("bp_grant_id", grant_log[gl0], 2);
    while (busy || dv != 0) step();

    do_reset();
    rc0 = rsp_count;
    dv = 4'b1000; da[3] = 8'h77; db[3] = 8'h11;
    step();
    drst = 1;
    step();
    drst = 0;
    dv = 4'b1001;
    da[0] = 8'h10; db[0] = 8'h20; da[3] = 8'h30; db[3] = 8'h40;
    gl0 = grant_log.size();
    step();
    check("rst_mid_win", grant_log[gl0], 0);
    repeat (3) step();
    check("rst_mid_cnt", rsp_count, rc0 + 1);
    while (busy || dv != 0) step();

    do_reset();
    rc0 = rsp_count;
    while (rsp_count < rc0 + 10000 && cyc < 90000) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!dv[i] && $urandom_range(0, 3) != 0) begin
          dv[i] = 1'b1;
          da[i] = N'($urandom);
          db[i] = N'($urandom);
        end
      end
      dr = ($urandom_range(0, 7) != 0);
      step();
    end
    check("rand_ops", rsp_count - rc0, 10000);
    check("rand_q", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
